// File: rtl/axi_slave_mem_responder_if.sv
// Purpose: AXI4 signal bundle (AW/W/B/AR/R channels) for one slave endpoint.
// Ports/modports:
//   master - drives AW/W/AR payload+valid, BREADY, RREADY
//   slave  - drives AWREADY, WREADY, B payload+valid, ARREADY, R payload+valid
interface axi_slave_mem_responder_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // write address channel
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [3:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  // write data channel
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  // write response channel
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  // read address channel
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  // read data channel
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_slave_mem_responder.sv
// Purpose: AXI4 slave endpoint backed by a local word-addressed memory.
//   INCR bursts up to 16 beats, independent write and read engines,
//   SLVERR for beats outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*STRB).
// Ports:
//   ACLK   - clock, all logic on posedge
//   ARESET - asynchronous reset, active-high
//   bus    - AXI4 slave modport (AW/W/B/AR/R channels); all outputs registered
module axi_slave_mem_responder #(
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                       ACLK,
  input logic                       ARESET,
  axi_slave_mem_responder_if.slave  bus
);

  localparam int unsigned       STRB_W    = DATA_W / 8;
  localparam int unsigned       LSB       = $clog2(STRB_W);
  localparam int unsigned       IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(MEM_WORDS * STRB_W);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(STRB_W);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Addresses below BASE_ADDR wrap to a large offset, so one compare covers both bounds.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < WIN_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

  // ---------------- write engine ----------------
  w_state_t          w_state, w_next;
  logic              awready, wready, bvalid;
  logic [ID_W-1:0]   bid, aw_id;
  logic [1:0]        bresp;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len, w_cnt;
  logic              w_err;
  logic              aw_hs, w_hs, b_hs;
  logic              w_beat_last, w_beat_err;

  assign aw_hs       = bus.AWVALID && awready;
  assign w_hs        = bus.WVALID && wready;
  assign b_hs        = bvalid && bus.BREADY;
  assign w_beat_last = (w_cnt == w_len);
  // A beat is in error if it falls outside the window or WLAST disagrees with the count.
  assign w_beat_err  = !in_range(w_addr) || (bus.WLAST != w_beat_last);

  // Write next-state
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_beat_last) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write state, registered handshake outputs, burst tracking
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      aw_id   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      // Ready/valid follow the next state, so they stay low during reset and rise one edge later.
      awready <= (w_next == W_IDLE);
      wready  <= (w_next == W_DATA);
      bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        aw_id  <= bus.AWID;
        w_addr <= bus.AWADDR;
        w_len  <= bus.AWLEN;
        w_cnt  <= '0;
        w_err  <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr + STEP;
        w_cnt  <= w_cnt + 4'd1;
        w_err  <= w_err || w_beat_err;
        if (w_beat_last) begin
          bid   <= aw_id;
          bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-masked memory write; out-of-window beats are dropped. Memory is never reset.
  always_ff @(posedge ACLK) begin
    if (w_hs && in_range(w_addr)) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (bus.WSTRB[i]) mem[word_idx(w_addr)][i*8 +: 8] <= bus.WDATA[i*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t          r_state, r_next;
  logic              arready, rvalid, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ADDR_W-1:0] r_addr, r_next_addr, fetch_addr;
  logic [3:0]        r_len, r_cnt;
  logic              ar_hs, r_hs, fetch_ok;
  logic [DATA_W-1:0] fetch_data;

  assign ar_hs       = bus.ARVALID && arready;
  assign r_hs        = rvalid && bus.RREADY;
  assign r_next_addr = r_addr + STEP;
  // Beat 0 comes from ARADDR; later beats from the incremented burst address.
  assign fetch_addr  = (r_state == R_IDLE) ? bus.ARADDR : r_next_addr;
  assign fetch_ok    = in_range(fetch_addr);
  assign fetch_data  = fetch_ok ? mem[word_idx(fetch_addr)] : '0;

  // Read next-state
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read state and registered R beat; beat only reloads on AR or a non-final R handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_addr <= bus.ARADDR;
        r_len  <= bus.ARLEN;
        r_cnt  <= '0;
        rid    <= bus.ARID;
        rdata  <= fetch_data;
        rresp  <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
        rlast  <= (bus.ARLEN == 4'd0);
      end else if (r_hs && !rlast) begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt + 4'd1;
        rdata  <= fetch_data;
        rresp  <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
        rlast  <= ((r_cnt + 4'd1) == r_len);
      end
    end
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BID     = bid;
  assign bus.BRESP   = bresp;
  assign bus.BVALID  = bvalid;
  assign bus.ARREADY = arready;
  assign bus.RID     = rid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;
  assign bus.RLAST   = rlast;
  assign bus.RVALID  = rvalid;

endmodule
